// File: rtl/vector_lsu.sv
// Strided vector load/store engine: walks LANES addresses base + k*stride, one per cycle,
// and collects load returns through a READ_LAT-deep valid/lane-index pipeline.
//
// state | meaning
// IDLE  | waiting for start_i, operands latched on acceptance
// STORE | issuing one write per cycle, lane 0 first
// LOAD  | issuing one read per cycle, returns captured READ_LAT cycles later
// DRAIN | all reads issued, waiting for the last return
// DONE  | one-cycle completion pulse, start_i ignored
module vector_lsu #(
    parameter int LANES    = 8,
    parameter int READ_LAT = 2
) (
    input  logic                  CLK,
    input  logic                  RST_n,
    input  logic                  start_i,
    input  logic                  store_i,
    input  logic                  byte_mode_i,
    input  logic [31:0]           base_addr_i,
    input  logic [31:0]           stride_i,
    input  logic [32*LANES-1:0]   vdata_i,
    output logic [32*LANES-1:0]   vdata_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [31:0]           mem_address_o,
    output logic [31:0]           mem_data_o,
    output logic                  mem_wren_o,
    output logic                  mem_byte_mode_o,
    input  logic [31:0]           mem_data_i
);

    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

    typedef enum logic [2:0] {IDLE, STORE, LOAD, DRAIN, DONE} state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     cnt_q;
    logic [31:0]          addr_q;
    logic [31:0]          stride_q;
    logic                 byte_q;
    logic [32*LANES-1:0]  sdata_q;
    logic [32*LANES-1:0]  lbuf_q, lbuf_d;
    logic [READ_LAT-1:0]  pv_q;
    logic [IDX_W-1:0]     pidx_q [READ_LAT];

    logic                 issuing;
    logic                 cap;
    logic [IDX_W-1:0]     cap_idx;
    logic [IDX_W-1:0]     issue_idx;
    logic [31:0]          cap_word;

    assign issuing   = (state_q == STORE) || (state_q == LOAD);
    assign cap       = pv_q[READ_LAT-1];
    assign cap_idx   = pidx_q[READ_LAT-1];
    // cnt_q counts lanes still to issue after the current one, down to zero
    assign issue_idx = LAST_IDX - cnt_q;
    assign cap_word  = byte_q ? {24'h0, mem_data_i[7:0]} : mem_data_i;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = store_i ? STORE : LOAD;
            STORE:   if (cnt_q == '0) state_d = DONE;
            LOAD:    if (cnt_q == '0) state_d = DRAIN;
            DRAIN:   if (cap && (cap_idx == LAST_IDX)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        lbuf_d = lbuf_q;
        for (int k = 0; k < LANES; k++) begin
            if (cap && (cap_idx == IDX_W'(k))) lbuf_d[32*k +: 32] = cap_word;
        end
    end

    always_comb begin
        busy_o          = (state_q == STORE) || (state_q == LOAD) || (state_q == DRAIN);
        done_o          = (state_q == DONE);
        mem_address_o   = issuing ? addr_q : 32'h0;
        mem_wren_o      = (state_q == STORE);
        mem_data_o      = 32'h0;
        if (state_q == STORE) mem_data_o = byte_q ? {24'h0, sdata_q[7:0]} : sdata_q[31:0];
        mem_byte_mode_o = busy_o & byte_q;
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            stride_q <= '0;
            byte_q   <= 1'b0;
            sdata_q  <= '0;
            lbuf_q   <= '0;
            vdata_o  <= '0;
            pv_q     <= '0;
            for (int j = 0; j < READ_LAT; j++) pidx_q[j] <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && start_i) begin
                addr_q   <= base_addr_i;
                stride_q <= stride_i;
                byte_q   <= byte_mode_i;
                sdata_q  <= vdata_i;
                cnt_q    <= LAST_IDX;
            end else if (issuing) begin
                addr_q  <= addr_q + stride_q;
                sdata_q <= sdata_q >> 32;
                if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
            end
            pv_q[0]   <= (state_q == LOAD);
            pidx_q[0] <= issue_idx;
            for (int j = 1; j < READ_LAT; j++) begin
                pv_q[j]   <= pv_q[j-1];
                pidx_q[j] <= pidx_q[j-1];
            end
            lbuf_q <= lbuf_d;
            // publish the whole vector only once the final lane has landed
            if (state_q == DRAIN && state_d == DONE) vdata_o <= lbuf_d;
        end
    end

endmodule

// File: tb/tb_vector_lsu.sv
// Directed bench for vector_lsu: a READ_LAT=2 memory model plus cycle-by-cycle
// expected address/data/handshake values computed from the operation parameters.
module tb_vector_lsu;

    localparam int LANES = 8;
    localparam int RL    = 2;

    logic                CLK = 1'b0;
    logic                RST_n;
    logic                start_i;
    logic                store_i;
    logic                byte_mode_i;
    logic [31:0]         base_addr_i;
    logic [31:0]         stride_i;
    logic [32*LANES-1:0] vdata_i;
    logic [32*LANES-1:0] vdata_o;
    logic                busy_o;
    logic                done_o;
    logic [31:0]         mem_address_o;
    logic [31:0]         mem_data_o;
    logic                mem_wren_o;
    logic                mem_byte_mode_o;
    logic [31:0]         mem_data_i = 32'h0;

    logic [31:0]         mem [64];
    logic [31:0]         rd_p1 = 32'h0;

    int                  n_vec = 0;
    int                  n_err = 0;
    logic [32*LANES-1:0] model_v;
    logic [32*LANES-1:0] vd, ev;
    int                  n_done, n_wr;

    vector_lsu #(.LANES(LANES), .READ_LAT(RL)) dut (
        .CLK(CLK), .RST_n(RST_n), .start_i(start_i), .store_i(store_i),
        .byte_mode_i(byte_mode_i), .base_addr_i(base_addr_i), .stride_i(stride_i),
        .vdata_i(vdata_i), .vdata_o(vdata_o), .busy_o(busy_o), .done_o(done_o),
        .mem_address_o(mem_address_o), .mem_data_o(mem_data_o), .mem_wren_o(mem_wren_o),
        .mem_byte_mode_o(mem_byte_mode_o), .mem_data_i(mem_data_i)
    );

    always #5 CLK = ~CLK;

    // memory: address in cycle k returns data valid in cycle k+2
    always @(posedge CLK) begin
        if (mem_wren_o) mem[mem_address_o[5:0]] <= mem_data_o;
        rd_p1      <= mem[mem_address_o[5:0]];
        mem_data_i <= rd_p1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic run_op(input logic st, input logic bm, input logic [31:0] base,
                          input logic [31:0] stride, input logic [32*LANES-1:0] vdat,
                          input logic [32*LANES-1:0] exp_v);
        int          dc;
        logic [31:0] ea, ed;
        logic        wr, bz;
        dc = st ? LANES : LANES + RL;
        @(negedge CLK);
        start_i = 1'b1; store_i = st; byte_mode_i = bm;
        base_addr_i = base; stride_i = stride; vdata_i = vdat;
        @(negedge CLK);
        start_i = 1'b0; store_i = ~st; byte_mode_i = ~bm;
        base_addr_i = 32'hDEAD0000; stride_i = 32'h40; vdata_i = ~vdat;
        for (int c = 0; c <= dc + 1; c++) begin
            wr = st && (c < LANES);
            bz = (c < dc);
            ea = (c < LANES) ? base + 32'(c) * stride : 32'h0;
            ed = wr ? (bm ? {24'h0, vdat[32*c +: 8]} : vdat[32*c +: 32]) : 32'h0;
            if (c == dc && !st) model_v = exp_v;
            check("addr", mem_address_o, ea);
            check("wdata", mem_data_o, ed);
            check("wren", {31'h0, mem_wren_o}, {31'h0, wr});
            check("busy", {31'h0, busy_o}, {31'h0, bz});
            check("done", {31'h0, done_o}, {31'h0, (c == dc)});
            check("bmode", {31'h0, mem_byte_mode_o}, {31'h0, bz && bm});
            check("vhold", {31'h0, (vdata_o === model_v)}, 32'h1);
            if (c == dc && !st)
                for (int k = 0; k < LANES; k++) check("lane", vdata_o[32*k +: 32], exp_v[32*k +: 32]);
            @(negedge CLK);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: got hang expected finish");
        $fatal(1);
    end

    initial begin
        RST_n = 1'b0; start_i = 1'b0; store_i = 1'b0; byte_mode_i = 1'b0;
        base_addr_i = '0; stride_i = '0; vdata_i = '0;
        model_v = '0;
        #3;
        check("rst_busy", {31'h0, busy_o}, 32'h0);
        check("rst_done", {31'h0, done_o}, 32'h0);
        check("rst_addr", mem_address_o, 32'h0);
        check("rst_wren", {31'h0, mem_wren_o}, 32'h0);
        check("rst_vdata", vdata_o[31:0], 32'h0);
        @(negedge CLK);
        RST_n = 1'b1;

        // word store then word load of the same region
        for (int k = 0; k < LANES; k++) vd[32*k +: 32] = 32'hA0 + 32'(k);
        run_op(1'b1, 1'b0, 32'h0001_0000, 32'h1, vd, '0);
        run_op(1'b0, 1'b0, 32'h0001_0000, 32'h1, {LANES{32'h5555_5555}}, vd);

        // byte store, then a word store of 0xFFFFFF80 with stride 0
        for (int k = 0; k < LANES; k++) vd[32*k +: 32] = 32'h1234_56F0 + 32'(k);
        run_op(1'b1, 1'b1, 32'h20, 32'h1, vd, '0);
        run_op(1'b1, 1'b0, 32'h28, 32'h0, {LANES{32'hFFFF_FF80}}, '0);

        // byte loads zero-extend
        run_op(1'b0, 1'b1, 32'h28, 32'h0, '0, {LANES{32'h0000_0080}});
        for (int k = 0; k < LANES; k++) ev[32*k +: 32] = 32'hF0 + 32'(k);
        run_op(1'b0, 1'b1, 32'h20, 32'h1, '0, ev);

        // address wrap
        run_op(1'b1, 1'b0, 32'hFFFF_FFFE, 32'h1, {LANES{32'h0BAD_F00D}}, '0);

        // start held through the whole store and the DONE cycle
        @(negedge CLK);
        start_i = 1'b1; store_i = 1'b1; byte_mode_i = 1'b0;
        base_addr_i = 32'h30; stride_i = 32'h1; vdata_i = vd;
        n_done = 0; n_wr = 0;
        for (int c = 0; c < 14; c++) begin
            @(negedge CLK);
            n_done += int'(done_o);
            n_wr   += int'(mem_wren_o);
            if (c == 9) start_i = 1'b0;
        end
        check("held_done", 32'(n_done), 32'd1);
        check("held_wren", 32'(n_wr), 32'd8);
        check("held_busy", {31'h0, busy_o}, 32'h0);

        // reset in cycle 3 of a store
        start_i = 1'b1; store_i = 1'b1; base_addr_i = 32'h10; stride_i = 32'h1;
        @(negedge CLK);
        start_i = 1'b0;
        for (int c = 0; c < 3; c++) @(negedge CLK);
        check("pre_rst_wren", {31'h0, mem_wren_o}, 32'h1);
        check("pre_rst_addr", mem_address_o, 32'h13);
        #1;
        RST_n = 1'b0;
        model_v = '0;
        #1;
        check("rst_mid_wren", {31'h0, mem_wren_o}, 32'h0);
        check("rst_mid_busy", {31'h0, busy_o}, 32'h0);
        check("rst_mid_addr", mem_address_o, 32'h0);
        check("rst_mid_bmode", {31'h0, mem_byte_mode_o}, 32'h0);
        check("rst_mid_vdata", vdata_o[31:0], 32'h0);
        start_i = 1'b1;
        n_done = 0; n_wr = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            n_done += int'(done_o) + int'(busy_o);
            n_wr   += int'(mem_wren_o);
        end
        check("rst_start_act", 32'(n_done), 32'd0);
        check("rst_start_wr", 32'(n_wr), 32'd0);
        start_i = 1'b0;
        RST_n = 1'b1;
        @(negedge CLK);
        check("post_rst_busy", {31'h0, busy_o}, 32'h0);

        // first start after release works normally
        run_op(1'b0, 1'b0, 32'h28, 32'h0, '0, {LANES{32'hFFFF_FF80}});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
